// File: rtl/dual_port_memory_ctrl_if.sv
// Request/response bundle for dual_port_memory_ctrl.
// Port A is a read-only fetch port. Port B is a load/store port with byte enables.
// The master drives requests. The slave (the memory) drives ready and the responses.
interface dual_port_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    a_req_valid;
  logic                    a_req_ready;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic                    a_resp_valid;
  logic [DATA_WIDTH-1:0]   a_resp_data;

  logic                    b_req_valid;
  logic                    b_req_ready;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic                    b_we;
  logic [DATA_WIDTH/8-1:0] b_be;
  logic [DATA_WIDTH-1:0]   b_wdata;
  logic                    b_resp_valid;
  logic [DATA_WIDTH-1:0]   b_resp_data;
  logic                    b_resp_err;

  modport master (
    output a_req_valid, a_addr,
    input  a_req_ready, a_resp_valid, a_resp_data,
    output b_req_valid, b_addr, b_we, b_be, b_wdata,
    input  b_req_ready, b_resp_valid, b_resp_data, b_resp_err
  );

  modport slave (
    input  a_req_valid, a_addr,
    output a_req_ready, a_resp_valid, a_resp_data,
    input  b_req_valid, b_addr, b_we, b_be, b_wdata,
    output b_req_ready, b_resp_valid, b_resp_data, b_resp_err
  );
endinterface

// File: rtl/dual_port_memory_ctrl.sv
// Dual-port word memory with a per-port programmable response latency.
// Port A is a read-only instruction fetch port. Port B handles data loads and stores.
// Optional feature macro: MEM_BOUNDS_CHECK_EN.
//   - When it is defined, an address with non-zero bits above the word index is
//     out of range. Such an access reads 0, and a port B write to it is dropped.
//     Port B also flags that access on b_resp_err.
//   - When it is undefined, the upper address bits are ignored. Addresses then
//     alias modulo DEPTH_WORDS, and b_resp_err is always 0.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is 1 only in IDLE. Request inputs other than valid are sampled only on
// that accept edge. resp_valid is a single-cycle pulse. It rises LAT edges after
// the accept edge, and there is no response backpressure. req_ready returns
// together with the pulse, so a port accepts at most one request every LAT+1 cycles.
module dual_port_memory_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_WIDTH  = 32,
  parameter int LAT_A       = 1,
  parameter int LAT_B       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_port_memory_ctrl_if.slave  bus,
  output logic                    dbg_a_wait_o,
  output logic                    dbg_b_wait_o
);
  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_W    = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int HI_LSB   = IDX_W + OFF_W;
  localparam int CNT_A_W  = (LAT_A > 1) ? $clog2(LAT_A) : 1;
  localparam int CNT_B_W  = (LAT_B > 1) ? $clog2(LAT_B) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  state_e                a_state_q;
  logic [CNT_A_W-1:0]    a_cnt_q;
  logic                  a_ready_q;
  logic                  a_rvalid_q;
  logic [DATA_WIDTH-1:0] a_hold_q;
  logic [DATA_WIDTH-1:0] a_rdata_q;

  state_e                b_state_q;
  logic [CNT_B_W-1:0]    b_cnt_q;
  logic                  b_ready_q;
  logic                  b_rvalid_q;
  logic [DATA_WIDTH-1:0] b_hold_q;
  logic                  b_err_hold_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;
  logic                  b_err_q;

  logic [IDX_W-1:0]      a_idx;
  logic [IDX_W-1:0]      b_idx;
  logic                  a_in_range;
  logic                  b_in_range;
  logic                  a_accept;
  logic                  b_accept;
  logic                  b_wr_en;
  logic                  unused_addr;

  assign a_idx    = bus.a_addr[HI_LSB-1:OFF_W];
  assign b_idx    = bus.b_addr[HI_LSB-1:OFF_W];
  assign a_accept = bus.a_req_valid && a_ready_q;
  assign b_accept = bus.b_req_valid && b_ready_q;
  assign b_wr_en  = b_accept && bus.b_we && b_in_range;

  // The byte-offset bits (and, without bounds checking, the upper bits) take no part in the access.
  assign unused_addr = ^{bus.a_addr, bus.b_addr};

`ifdef MEM_BOUNDS_CHECK_EN
  assign a_in_range = ((bus.a_addr >> HI_LSB) == '0);
  assign b_in_range = ((bus.b_addr >> HI_LSB) == '0);
`else
  assign a_in_range = 1'b1;
  assign b_in_range = 1'b1;
`endif

  // Commit port B byte writes on the accept edge; the array itself is never reset
  always_ff @(posedge clk) begin
    if (b_wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.b_be[i]) mem_q[b_idx][i*8 +: 8] <= bus.b_wdata[i*8 +: 8];
      end
    end
  end

  // Port A FSM: capture read data on accept (old word on collision), count down, then pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_q  <= S_IDLE;
      a_cnt_q    <= '0;
      a_ready_q  <= 1'b1;
      a_rvalid_q <= 1'b0;
      a_hold_q   <= '0;
      a_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= 1'b0;
      case (a_state_q)
        S_IDLE: begin
          if (a_accept) begin
            a_hold_q  <= a_in_range ? mem_q[a_idx] : '0;
            a_cnt_q   <= CNT_A_W'(LAT_A - 1);
            a_ready_q <= 1'b0;
            a_state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (a_cnt_q == '0) begin
            a_rvalid_q <= 1'b1;
            a_rdata_q  <= a_hold_q;
            a_ready_q  <= 1'b1;
            a_state_q  <= S_IDLE;
          end else begin
            a_cnt_q <= a_cnt_q - CNT_A_W'(1);
          end
        end
        default: begin
          a_state_q <= S_IDLE;
          a_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Port B FSM: same timing as port A; writes answer with data 0, reads with the pre-edge word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q    <= S_IDLE;
      b_cnt_q      <= '0;
      b_ready_q    <= 1'b1;
      b_rvalid_q   <= 1'b0;
      b_hold_q     <= '0;
      b_err_hold_q <= 1'b0;
      b_rdata_q    <= '0;
      b_err_q      <= 1'b0;
    end else begin
      b_rvalid_q <= 1'b0;
      case (b_state_q)
        S_IDLE: begin
          if (b_accept) begin
            b_hold_q     <= (bus.b_we || !b_in_range) ? '0 : mem_q[b_idx];
            b_err_hold_q <= !b_in_range;
            b_cnt_q      <= CNT_B_W'(LAT_B - 1);
            b_ready_q    <= 1'b0;
            b_state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (b_cnt_q == '0) begin
            b_rvalid_q <= 1'b1;
            b_rdata_q  <= b_hold_q;
            b_err_q    <= b_err_hold_q;
            b_ready_q  <= 1'b1;
            b_state_q  <= S_IDLE;
          end else begin
            b_cnt_q <= b_cnt_q - CNT_B_W'(1);
          end
        end
        default: begin
          b_state_q <= S_IDLE;
          b_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.a_req_ready  = a_ready_q;
  assign bus.a_resp_valid = a_rvalid_q;
  assign bus.a_resp_data  = a_rdata_q;
  assign bus.b_req_ready  = b_ready_q;
  assign bus.b_resp_valid = b_rvalid_q;
  assign bus.b_resp_data  = b_rdata_q;
  assign bus.b_resp_err   = b_err_q;
  assign dbg_a_wait_o     = (a_state_q == S_WAIT);
  assign dbg_b_wait_o     = (b_state_q == S_WAIT);
endmodule

// File: tb/tb_dual_port_memory_ctrl.sv
// Testbench for dual_port_memory_ctrl (LAT_A = 2, LAT_B = 3, DEPTH_WORDS = 16384).
// The drivers push the expected data, error and response cycle for each request.
// The monitor pops and compares them on every resp_valid pulse.
module tb_dual_port_memory_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16384;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic a_wait, b_wait;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dual_port_memory_ctrl #(
    .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .LAT_A(LAT_A), .LAT_B(LAT_B)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_a_wait_o (a_wait),
    .dbg_b_wait_o (b_wait)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] a_exp_q[$];
  logic [DW-1:0] b_exp_q[$];
  logic          b_err_q[$];
  int            a_due_q[$];
  int            b_due_q[$];
  int            tests_run = 0;
  int            fails = 0;
  int            a_pulses = 0;
  int            b_pulses = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.a_resp_valid === 1'b1) begin
      a_pulses++;
      if (a_exp_q.size() == 0) begin
        check_bit("a_unexpected_resp", 1'b1, 1'b0);
      end else begin
        check("a_resp_data", bus.a_resp_data, a_exp_q.pop_front());
        check("a_resp_cycle", 32'(cyc), 32'(a_due_q.pop_front()));
      end
    end
    if (bus.b_resp_valid === 1'b1) begin
      b_pulses++;
      if (b_exp_q.size() == 0) begin
        check_bit("b_unexpected_resp", 1'b1, 1'b0);
      end else begin
        check("b_resp_data", bus.b_resp_data, b_exp_q.pop_front());
        check_bit("b_resp_err", bus.b_resp_err, b_err_q.pop_front());
        check("b_resp_cycle", 32'(cyc), 32'(b_due_q.pop_front()));
      end
    end
  end

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic a_issue(input logic [AW-1:0] addr, input logic [DW-1:0] exp_d);
    int n = 0;
    bus.a_addr = addr;
    bus.a_req_valid = 1'b1;
    while (bus.a_req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check_bit("a_ready_timeout", 1'b0, 1'b1);
      bus.a_req_valid = 1'b0;
      return;
    end
    a_exp_q.push_back(exp_d);
    a_due_q.push_back(cyc + 1 + LAT_A);
    @(negedge clk);
    bus.a_req_valid = 1'b0;
  endtask

  task automatic b_issue(input logic [AW-1:0] addr, input logic we, input logic [3:0] be,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_d, input logic exp_e);
    int n = 0;
    bus.b_addr = addr;
    bus.b_we = we;
    bus.b_be = be;
    bus.b_wdata = wd;
    bus.b_req_valid = 1'b1;
    while (bus.b_req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check_bit("b_ready_timeout", 1'b0, 1'b1);
      bus.b_req_valid = 1'b0;
      return;
    end
    b_exp_q.push_back(exp_d);
    b_err_q.push_back(exp_e);
    b_due_q.push_back(cyc + 1 + LAT_B);
    @(negedge clk);
    bus.b_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_bit("drain_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pa, pb;
    bus.a_req_valid = 1'b0;
    bus.a_addr = '0;
    bus.b_req_valid = 1'b0;
    bus.b_addr = '0;
    bus.b_we = 1'b0;
    bus.b_be = '0;
    bus.b_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check_bit("rst_a_ready", bus.a_req_ready, 1'b1);
    check_bit("rst_b_ready", bus.b_req_ready, 1'b1);
    check_bit("rst_a_valid", bus.a_resp_valid, 1'b0);
    check_bit("rst_b_valid", bus.b_resp_valid, 1'b0);
    check("rst_a_data", bus.a_resp_data, 32'h0);
    check("rst_b_data", bus.b_resp_data, 32'h0);
    check_bit("rst_b_err", bus.b_resp_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write, then read back with LAT_B = 3.
    b_issue(32'h40, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    b_issue(32'h40, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte enables: be = 0101 replaces bytes 0 and 2 of 0x11223344 -> 0x11BB33DD.
    b_issue(32'h80, 1'b1, 4'b1111, 32'h11223344, 32'h0, 1'b0);
    b_issue(32'h80, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
    b_issue(32'h80, 1'b0, 4'b0000, 32'h0, 32'h11BB33DD, 1'b0);
    // be = 1000 replaces only byte 3 -> 0xEEBB33DD.
    b_issue(32'h80, 1'b1, 4'b1000, 32'hEEFFFFFF, 32'h0, 1'b0);
    b_issue(32'h82, 1'b0, 4'b0000, 32'h0, 32'hEEBB33DD, 1'b0);
    wait_drain();

    // Collision: A read and B write to the same word on the same edge, so A gets the old word.
    b_issue(32'h100, 1'b1, 4'b1111, 32'h1, 32'h0, 1'b0);
    wait_drain();
    fork
      a_issue(32'h100, 32'h1);
      b_issue(32'h100, 1'b1, 4'b1111, 32'h2, 32'h0, 1'b0);
    join
    wait_drain();
    a_issue(32'h103, 32'h2);
    wait_drain();

    // Handshake: valid held high for 10 cycles with LAT_A = 2 accepts on 0, 3, 6, 9.
    bus.a_addr = 32'h40;
    bus.a_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_bit("a_hs_ready", bus.a_req_ready, (i % 3) == 0);
      check_bit("a_hs_wait_state", a_wait, (i % 3) != 0);
      if ((i % 3) == 0) begin
        a_exp_q.push_back(32'hDEADBEEF);
        a_due_q.push_back(cyc + 1 + LAT_A);
      end
      @(negedge clk);
    end
    bus.a_req_valid = 1'b0;
    wait_drain();

    // Bounds / aliasing: 0x10000 is word 0 plus a bit above the 14-bit word index.
    b_issue(32'h0, 1'b1, 4'b1111, 32'h12345678, 32'h0, 1'b0);
    b_issue(32'h10000, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, BOUNDS);
    wait_drain();
    a_issue(32'h0, BOUNDS ? 32'h12345678 : 32'hCAFEF00D);
    a_issue(32'h10000, BOUNDS ? 32'h0 : 32'hCAFEF00D);
    b_issue(32'h10000, 1'b0, 4'b0000, 32'h0, BOUNDS ? 32'h0 : 32'hCAFEF00D, BOUNDS);
    b_issue(32'h0, 1'b0, 4'b0000, 32'h0, BOUNDS ? 32'h12345678 : 32'hCAFEF00D, 1'b0);
    wait_drain();

    // Reset mid-WAIT: both pending responses are dropped, but the B write stays committed.
    bus.a_addr = 32'h40;
    bus.a_req_valid = 1'b1;
    bus.b_addr = 32'h200;
    bus.b_we = 1'b1;
    bus.b_be = 4'b1111;
    bus.b_wdata = 32'h5A5A5A5A;
    bus.b_req_valid = 1'b1;
    @(negedge clk);
    bus.a_req_valid = 1'b0;
    bus.b_req_valid = 1'b0;
    check_bit("mid_a_wait", a_wait, 1'b1);
    check_bit("mid_b_wait", b_wait, 1'b1);
    check_bit("mid_a_ready", bus.a_req_ready, 1'b0);
    check_bit("mid_b_ready", bus.b_req_ready, 1'b0);
    pa = a_pulses;
    pb = b_pulses;
    rst_n = 1'b0;
    #1;
    check_bit("rstw_a_ready", bus.a_req_ready, 1'b1);
    check_bit("rstw_b_ready", bus.b_req_ready, 1'b1);
    check_bit("rstw_a_valid", bus.a_resp_valid, 1'b0);
    check_bit("rstw_b_valid", bus.b_resp_valid, 1'b0);
    check("rstw_a_data", bus.a_resp_data, 32'h0);
    check("rstw_b_data", bus.b_resp_data, 32'h0);
    check_bit("rstw_a_wait", a_wait, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rstw_no_a_pulse", 32'(a_pulses), 32'(pa));
    check("rstw_no_b_pulse", 32'(b_pulses), 32'(pb));
    b_issue(32'h200, 1'b0, 4'b0000, 32'h0, 32'h5A5A5A5A, 1'b0);
    a_issue(32'h200, 32'h5A5A5A5A);
    wait_drain();

    // ---------------- final report ----------------
    check("queues_empty", 32'(a_exp_q.size() + b_exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
